// File: rtl/board_scan_renderer.sv
// ---------------------------------------------------------------------------
// board_scan_renderer
//
// Pixel-side reader of the playfield. Produces 640x480 VGA timing from the
// system clock, turns every in-board pixel into a board cell query, samples
// the returned cell colour, overlays the falling piece and a white frame
// around the board, and drives registered rgb/hsync/vsync to the pins.
//
// Pipeline (advances only on the pixel tick):
//   stage 0 : h/v counters and combinational region decode
//   stage 1 : cell query (x_vga2/y_vga2), region flags, piece-hit flag
//   stage 2 : final colour select and delayed syncs
//
// Ports:
//   clk                  system clock
//   reset                asynchronous reset, active low
//   x_vga2 / y_vga2      board cell being queried (0 outside the board)
//   color                board colour of the queried cell (combinational)
//   x1..x4 / y1..y4      falling-piece cells; rows above 19 never match
//   block_type           falling-piece palette index
//   rgb                  pixel colour {B[3:0], G[3:0], R[3:0]}
//   hsync / vsync        active-low syncs, aligned with rgb
//   frame_tick           one-clk pulse at the start of vertical blanking
// ---------------------------------------------------------------------------
module board_scan_renderer #(
    parameter int CLK_DIV   = 4,
    parameter int BOARD_X0  = 240,
    parameter int BOARD_Y0  = 80,
    parameter int CELL_LOG2 = 4,
    parameter int BORDER    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  x_vga2,
    output logic [4:0]  y_vga2,
    input  logic [11:0] color,
    input  logic [3:0]  x1,
    input  logic [3:0]  x2,
    input  logic [3:0]  x3,
    input  logic [3:0]  x4,
    input  logic [4:0]  y1,
    input  logic [4:0]  y2,
    input  logic [4:0]  y3,
    input  logic [4:0]  y4,
    input  logic [2:0]  block_type,
    output logic [11:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    // Board window bounds; 11 bits so that "+ BORDER" cannot overflow.
    localparam logic [10:0] BX_LO = 11'(BOARD_X0);
    localparam logic [10:0] BX_HI = 11'(BOARD_X0 + 160);
    localparam logic [10:0] BY_LO = 11'(BOARD_Y0);
    localparam logic [10:0] BY_HI = 11'(BOARD_Y0 + 320);
    localparam logic [10:0] BRD   = 11'(BORDER);
    localparam logic [9:0]  BX0_10 = 10'(BOARD_X0);
    localparam logic [9:0]  BY0_10 = 10'(BOARD_Y0);

    function automatic logic [11:0] palette(input logic [2:0] idx);
        logic [11:0] c;
        case (idx)
            3'd0:    c = 12'h000;
            3'd1:    c = 12'hF00;
            3'd2:    c = 12'h0FF;
            3'd3:    c = 12'hF0F;
            3'd4:    c = 12'h0F8;
            3'd5:    c = 12'h08F;
            3'd6:    c = 12'h00F;
            default: c = 12'hDD4;
        endcase
        return c;
    endfunction

    logic [DIV_W-1:0] r_div;
    logic [9:0]       r_h_p0;
    logic [9:0]       r_v_p0;
    logic             w_pt;

    logic [10:0]      w_h11;
    logic [10:0]      w_v11;
    logic             w_vld_p0;
    logic             w_inb_p0;
    logic             w_outer_p0;
    logic             w_bdr_p0;
    logic             w_hs_on_p0;
    logic             w_vs_on_p0;
    logic [3:0]       w_cx_p0;
    logic [4:0]       w_cy_p0;
    logic             w_hit_p0;

    logic [3:0]       r_x_p1;
    logic [4:0]       r_y_p1;
    logic             r_vld_p1;
    logic             r_inb_p1;
    logic             r_bdr_p1;
    logic             r_hs_on_p1;
    logic             r_vs_on_p1;
    logic             r_hit_p1;

    logic [11:0]      r_rgb_p2;
    logic             r_hsync_p2;
    logic             r_vsync_p2;

    assign w_pt = (r_div == DIV_MAX);

    // ---- stage 0: pixel divider and h/v counters ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div  <= '0;
            r_h_p0 <= '0;
            r_v_p0 <= '0;
        end else begin
            r_div <= w_pt ? '0 : r_div + 1'b1;
            if (w_pt) begin
                if (r_h_p0 == 10'd799) begin
                    r_h_p0 <= '0;
                    r_v_p0 <= (r_v_p0 == 10'd524) ? 10'd0 : r_v_p0 + 10'd1;
                end else begin
                    r_h_p0 <= r_h_p0 + 10'd1;
                end
            end
        end
    end

    assign w_h11 = {1'b0, r_h_p0};
    assign w_v11 = {1'b0, r_v_p0};

    assign w_vld_p0   = (r_h_p0 < 10'd640) && (r_v_p0 < 10'd480);
    assign w_inb_p0   = (w_h11 >= BX_LO) && (w_h11 < BX_HI) &&
                        (w_v11 >= BY_LO) && (w_v11 < BY_HI);
    // Left/top edges written as "h + BORDER >= lo" to stay unsigned.
    assign w_outer_p0 = (w_h11 + BRD >= BX_LO) && (w_h11 < BX_HI + BRD) &&
                        (w_v11 + BRD >= BY_LO) && (w_v11 < BY_HI + BRD);
    assign w_bdr_p0   = w_outer_p0 && !w_inb_p0;
    assign w_hs_on_p0 = (r_h_p0 >= 10'd656) && (r_h_p0 <= 10'd751);
    assign w_vs_on_p0 = (r_v_p0 >= 10'd490) && (r_v_p0 <= 10'd491);

    // Wrap-around garbage outside the board is masked by w_inb_p0 below.
    assign w_cx_p0 = 4'((r_h_p0 - BX0_10) >> CELL_LOG2);
    assign w_cy_p0 = 5'((r_v_p0 - BY0_10) >> CELL_LOG2);

    assign w_hit_p0 = w_inb_p0 && (
        ((x1 == w_cx_p0) && (y1 == w_cy_p0) && (y1 <= 5'd19)) ||
        ((x2 == w_cx_p0) && (y2 == w_cy_p0) && (y2 <= 5'd19)) ||
        ((x3 == w_cx_p0) && (y3 == w_cy_p0) && (y3 <= 5'd19)) ||
        ((x4 == w_cx_p0) && (y4 == w_cy_p0) && (y4 <= 5'd19)));

    // ---- stage 1: cell query and region flags ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_x_p1     <= '0;
            r_y_p1     <= '0;
            r_vld_p1   <= 1'b0;
            r_inb_p1   <= 1'b0;
            r_bdr_p1   <= 1'b0;
            r_hs_on_p1 <= 1'b0;
            r_vs_on_p1 <= 1'b0;
            r_hit_p1   <= 1'b0;
        end else if (w_pt) begin
            r_x_p1     <= w_inb_p0 ? w_cx_p0 : 4'd0;
            r_y_p1     <= w_inb_p0 ? w_cy_p0 : 5'd0;
            r_vld_p1   <= w_vld_p0;
            r_inb_p1   <= w_inb_p0;
            r_bdr_p1   <= w_bdr_p0;
            r_hs_on_p1 <= w_hs_on_p0;
            r_vs_on_p1 <= w_vs_on_p0;
            r_hit_p1   <= w_hit_p0;
        end
    end

    // ---- stage 2: colour select and pin registers ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rgb_p2   <= 12'h000;
            r_hsync_p2 <= 1'b1;
            r_vsync_p2 <= 1'b1;
        end else if (w_pt) begin
            if (!r_vld_p1)
                r_rgb_p2 <= 12'h000;
            else if (r_inb_p1 && r_hit_p1)
                r_rgb_p2 <= palette(block_type);
            else if (r_inb_p1)
                r_rgb_p2 <= color;
            else if (r_bdr_p1)
                r_rgb_p2 <= 12'hFFF;
            else
                r_rgb_p2 <= 12'h000;
            r_hsync_p2 <= ~r_hs_on_p1;
            r_vsync_p2 <= ~r_vs_on_p1;
        end
    end

    assign x_vga2     = r_x_p1;
    assign y_vga2     = r_y_p1;
    assign rgb        = r_rgb_p2;
    assign hsync      = r_hsync_p2;
    assign vsync      = r_vsync_p2;
    assign frame_tick = w_pt && (r_h_p0 == 10'd0) && (r_v_p0 == 10'd480);

endmodule
